// File: rtl/dep_rule_loader_pkg.sv
// Shared types, widths and write-packing for the deparser rule-config loader.
// Feature macro DEP_RULE_LDR_INVALIDATE_EN is consumed by dep_rule_loader.
package dep_rule_loader_pkg;

   localparam int unsigned RULE_NUM          = 16;
   localparam int unsigned RULE_ID_W         = 6;
   localparam int unsigned TYPE_NUM          = 4;
   localparam int unsigned TYPE_WIDTH        = 16;
   localparam int unsigned TYPE_OFFSET_WIDTH = 8;
   localparam int unsigned KEY_FILED_NUM     = 8;
   localparam int unsigned KEY_OFFSET_WIDTH  = 5;
   localparam int unsigned HEAD_SHIFT_WIDTH  = 6;
   localparam int unsigned META_SHIFT_WIDTH  = 6;
   localparam int unsigned BUS_W             = 32;
   localparam int unsigned IDX_W             = 6;
   localparam int unsigned TYPE_IDX_W        = (TYPE_NUM > 1) ? $clog2(TYPE_NUM) : 1;
   localparam int unsigned KEY_IDX_W         = (KEY_FILED_NUM > 1) ? $clog2(KEY_FILED_NUM) : 1;
   localparam int unsigned SEQ_LEN           = 2 * TYPE_NUM + KEY_FILED_NUM + 3;

   localparam logic [2:0] SEL_RULE = 3'd0;
   localparam logic [2:0] SEL_TYPE = 3'd1;
   localparam logic [2:0] SEL_TOFF = 3'd2;
   localparam logic [2:0] SEL_KEY  = 3'd3;
   localparam logic [2:0] SEL_HEAD = 3'd4;
   localparam logic [2:0] SEL_META = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE, ST_TYPE, ST_TOFF, ST_KEY, ST_HEAD, ST_META, ST_COMMIT
   } state_t;

   typedef struct packed {
      logic [RULE_ID_W-1:0]                              rule_id;
      logic                                              rule_valid;
      logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]               type_data;
      logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]               type_mask;
      logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]        type_offset;
      logic [KEY_FILED_NUM-1:0]                          key_valid;
      logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH-1:0]    key_offset;
      logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH-1:0]    key_merge;
      logic [HEAD_SHIFT_WIDTH-1:0]                       head_shift;
      logic [META_SHIFT_WIDTH-1:0]                       meta_shift;
   } desc_t;

   typedef struct packed {
      logic             wren;
      logic [BUS_W-1:0] addr;
      logic [BUS_W-1:0] wdata;
   } wr_t;

   // Config write (strobe/addr/data) for a given phase and index; idle yields all zero.
   function automatic wr_t pack_write(input state_t st, input logic [IDX_W-1:0] idx,
                                      input desc_t d);
      wr_t                   w;
      logic [TYPE_IDX_W-1:0] ti;
      logic [KEY_IDX_W-1:0]  ki;
      w  = '0;
      ti = idx[TYPE_IDX_W-1:0];
      ki = idx[KEY_IDX_W-1:0];
      case (st)
         ST_TYPE: begin
            w.wren                      = 1'b1;
            w.addr[10:8]                = SEL_TYPE;
            w.addr[3:0]                 = idx[3:0];
            w.wdata[16 +: TYPE_WIDTH]   = d.type_data[ti];
            w.wdata[0 +: TYPE_WIDTH]    = d.type_mask[ti];
         end
         ST_TOFF: begin
            w.wren                          = 1'b1;
            w.addr[10:8]                    = SEL_TOFF;
            w.addr[3:0]                     = idx[3:0];
            w.wdata[0 +: TYPE_OFFSET_WIDTH] = d.type_offset[ti];
         end
         ST_KEY: begin
            w.wren                          = 1'b1;
            w.addr[10:8]                    = SEL_KEY;
            w.addr[5:0]                     = idx;
            w.wdata[16]                     = d.key_valid[ki];
            w.wdata[8 +: KEY_OFFSET_WIDTH]  = d.key_merge[ki];
            w.wdata[0 +: KEY_OFFSET_WIDTH]  = d.key_offset[ki];
         end
         ST_HEAD: begin
            w.wren                          = 1'b1;
            w.addr[10:8]                    = SEL_HEAD;
            w.wdata[0 +: HEAD_SHIFT_WIDTH]  = d.head_shift;
         end
         ST_META: begin
            w.wren                          = 1'b1;
            w.addr[10:8]                    = SEL_META;
            w.wdata[0 +: META_SHIFT_WIDTH]  = d.meta_shift;
         end
         ST_COMMIT: begin
            w.wren                   = 1'b1;
            w.addr[10:8]             = SEL_RULE;
            w.addr[0 +: RULE_ID_W]   = d.rule_id;
            w.wdata[0]               = d.rule_valid;
         end
         default: ;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/dep_rule_loader_if.sv
// Descriptor handshake plus deparser rule-config write bus of the rule loader.
interface dep_rule_loader_if;
   import dep_rule_loader_pkg::*;

   logic             desc_valid;
   logic             desc_ready;
   desc_t            desc;
   logic             rule_wren;
   logic [BUS_W-1:0] rule_wdata;
   logic [BUS_W-1:0] rule_addr;
   logic             busy;
   logic             done;

   modport master (
      output desc_valid, desc,
      input  desc_ready, rule_wren, rule_wdata, rule_addr, busy, done
   );

   modport slave (
      input  desc_valid, desc,
      output desc_ready, rule_wren, rule_wdata, rule_addr, busy, done
   );
endinterface

// File: rtl/dep_rule_loader.sv
// Serializes one rule descriptor into 32b deparser config writes, commit write last.
// DEP_RULE_LDR_INVALIDATE_EN: ruleValid=0 descriptors issue only the commit write.
module dep_rule_loader
   import dep_rule_loader_pkg::*;
(
   input logic               i_clk,
   input logic               i_rst_n,
   dep_rule_loader_if.slave  bus
);

   state_t           state;
   state_t           nxt_state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] nxt_idx;
   desc_t            shadow;
   desc_t            src;
   wr_t              wr;
   logic             accept;

   assign accept = bus.desc_valid & bus.desc_ready;

   // Phase sequencing; the index restarts at zero on every phase change.
   always_comb begin
      nxt_state = state;
      nxt_idx   = '0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
`ifdef DEP_RULE_LDR_INVALIDATE_EN
               nxt_state = bus.desc.rule_valid ? ST_TYPE : ST_COMMIT;
`else
               nxt_state = ST_TYPE;
`endif
            end
         end
         ST_TYPE: begin
            if (idx == IDX_W'(TYPE_NUM - 1)) nxt_state = ST_TOFF;
            else                              nxt_idx   = idx + IDX_W'(1);
         end
         ST_TOFF: begin
            if (idx == IDX_W'(TYPE_NUM - 1)) nxt_state = ST_KEY;
            else                              nxt_idx   = idx + IDX_W'(1);
         end
         ST_KEY: begin
            if (idx == IDX_W'(KEY_FILED_NUM - 1)) nxt_state = ST_HEAD;
            else                                   nxt_idx   = idx + IDX_W'(1);
         end
         ST_HEAD:   nxt_state = ST_META;
         ST_META:   nxt_state = ST_COMMIT;
         ST_COMMIT: nxt_state = ST_IDLE;
         default:   nxt_state = ST_IDLE;
      endcase
   end

   // The first write is built straight from the bus so it lands the cycle after accept.
   assign src = (state == ST_IDLE) ? bus.desc : shadow;
   assign wr  = pack_write(nxt_state, nxt_idx, src);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= ST_IDLE;
         idx            <= '0;
         shadow         <= '0;
         bus.rule_wren  <= 1'b0;
         bus.rule_addr  <= '0;
         bus.rule_wdata <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.desc_ready <= 1'b1;
      end else begin
         state          <= nxt_state;
         idx            <= nxt_idx;
         if (accept) shadow <= bus.desc;
         bus.rule_wren  <= wr.wren;
         bus.rule_addr  <= wr.addr;
         bus.rule_wdata <= wr.wdata;
         bus.busy       <= (nxt_state != ST_IDLE);
         bus.done       <= (state == ST_COMMIT);
         bus.desc_ready <= (nxt_state == ST_IDLE);
      end
   end

endmodule
